// File: rtl/instr_enc_pkg.sv
// Shared types for the instruction encoder/loader: op selects, MIPS opcode/funct
// constants, loader FSM states and small field-packing helpers.
package instr_enc_pkg;

    typedef enum logic [4:0] {
        OP_ADD, OP_ADDU, OP_SUB, OP_SUBU, OP_AND, OP_OR, OP_XOR, OP_NOR, OP_SLT,
        OP_SLL, OP_SRL, OP_SRA, OP_SLLV, OP_SRLV, OP_SRAV, OP_JR, OP_JALR,
        OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI,
        OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J, OP_JAL
    } op_sel_e;

    localparam logic [5:0] OPC_RTYPE = 6'h00, OPC_J     = 6'h02, OPC_JAL   = 6'h03,
                           OPC_BEQ   = 6'h04, OPC_BNE   = 6'h05, OPC_ADDI  = 6'h08,
                           OPC_ADDIU = 6'h09, OPC_SLTI  = 6'h0A, OPC_SLTIU = 6'h0B,
                           OPC_ANDI  = 6'h0C, OPC_ORI   = 6'h0D, OPC_XORI  = 6'h0E,
                           OPC_LUI   = 6'h0F, OPC_LW    = 6'h23, OPC_SW    = 6'h2B;

    localparam logic [5:0] FUNCT_SLL  = 6'h00, FUNCT_SRL  = 6'h02, FUNCT_SRA  = 6'h03,
                           FUNCT_SLLV = 6'h04, FUNCT_SRLV = 6'h06, FUNCT_SRAV = 6'h07,
                           FUNCT_JR   = 6'h08, FUNCT_JALR = 6'h09, FUNCT_ADD  = 6'h20,
                           FUNCT_ADDU = 6'h21, FUNCT_SUB  = 6'h22, FUNCT_SUBU = 6'h23,
                           FUNCT_AND  = 6'h24, FUNCT_OR   = 6'h25, FUNCT_XOR  = 6'h26,
                           FUNCT_NOR  = 6'h27, FUNCT_SLT  = 6'h2A;

    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_DRAIN, ST_DONE} state_e;

    typedef struct packed {
        logic        legal;
        logic [31:0] word;
    } enc_t;

    function automatic logic [31:0] r_word(input logic [4:0] rs, input logic [4:0] rt,
                                           input logic [4:0] rd, input logic [4:0] sh,
                                           input logic [5:0] fn);
        return {OPC_RTYPE, rs, rt, rd, sh, fn};
    endfunction

    function automatic logic [31:0] i_word(input logic [5:0] opc, input logic [4:0] rs,
                                           input logic [4:0] rt, input logic [15:0] imm);
        return {opc, rs, rt, imm};
    endfunction

    function automatic logic [31:0] j_word(input logic [5:0] opc, input logic [25:0] tgt);
        return {opc, tgt};
    endfunction

endpackage

// File: rtl/instr_enc_fifo.sv
// Small synchronous FIFO for encoded words; a pushed word becomes visible at the
// head only on the following cycle (no fall-through).
module instr_enc_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0]   FULL_CNT = DEPTH[PTR_W:0];
    localparam logic [PTR_W-1:0] PTR_ONE  = 1;
    localparam logic [PTR_W:0]   CNT_ONE  = 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             push_ok, pop_ok;

    assign full    = (count_q == FULL_CNT);
    assign empty   = (count_q == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign rdata   = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_ONE;
        if (push_ok && !pop_ok)      count_d = count_q + CNT_ONE;
        else if (!push_ok && pop_ok) count_d = count_q - CNT_ONE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/instr_encoder_loader.sv
// Encodes symbolic instruction requests into MIPS words, buffers them and streams
// them into instruction memory at consecutive word addresses.
module instr_encoder_loader
    import instr_enc_pkg::*;
#(
    parameter int unsigned        ADDR_W    = 32,
    parameter logic [ADDR_W-1:0]  BASE_ADDR = '0,
    parameter int unsigned        DEPTH     = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [4:0]        req_op,
    input  logic [4:0]        req_rs,
    input  logic [4:0]        req_rt,
    input  logic [4:0]        req_rd,
    input  logic [4:0]        req_shamt,
    input  logic [15:0]       req_imm,
    input  logic [25:0]       req_target,
    input  logic              req_last,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    input  logic              imem_ready,
    output logic              busy,
    output logic              done,
    output logic              err_illegal,
    output logic [ADDR_W-1:0] instr_count
);
    localparam logic [ADDR_W-1:0] ADDR_STEP = 4;
    localparam logic [ADDR_W-1:0] COUNT_ONE = 1;

    function automatic enc_t encode(input logic [4:0] op, input logic [4:0] rs,
                                    input logic [4:0] rt, input logic [4:0] rd,
                                    input logic [4:0] sh, input logic [15:0] imm,
                                    input logic [25:0] tgt);
        enc_t e;
        e.legal = 1'b1;
        e.word  = '0;
        case (op)
            OP_ADD:   e.word = r_word(rs, rt, rd, 5'd0, FUNCT_ADD);
            OP_ADDU:  e.word = r_word(rs, rt, rd, 5'd0, FUNCT_ADDU);
            OP_SUB:   e.word = r_word(rs, rt, rd, 5'd0, FUNCT_SUB);
            OP_SUBU:  e.word = r_word(rs, rt, rd, 5'd0, FUNCT_SUBU);
            OP_AND:   e.word = r_word(rs, rt, rd, 5'd0, FUNCT_AND);
            OP_OR:    e.word = r_word(rs, rt, rd, 5'd0, FUNCT_OR);
            OP_XOR:   e.word = r_word(rs, rt, rd, 5'd0, FUNCT_XOR);
            OP_NOR:   e.word = r_word(rs, rt, rd, 5'd0, FUNCT_NOR);
            OP_SLT:   e.word = r_word(rs, rt, rd, 5'd0, FUNCT_SLT);
            OP_SLL:   e.word = r_word(5'd0, rt, rd, sh, FUNCT_SLL);
            OP_SRL:   e.word = r_word(5'd0, rt, rd, sh, FUNCT_SRL);
            OP_SRA:   e.word = r_word(5'd0, rt, rd, sh, FUNCT_SRA);
            OP_SLLV:  e.word = r_word(rs, rt, rd, 5'd0, FUNCT_SLLV);
            OP_SRLV:  e.word = r_word(rs, rt, rd, 5'd0, FUNCT_SRLV);
            OP_SRAV:  e.word = r_word(rs, rt, rd, 5'd0, FUNCT_SRAV);
            OP_JR:    e.word = r_word(rs, 5'd0, 5'd0, 5'd0, FUNCT_JR);
            OP_JALR:  e.word = r_word(rs, 5'd0, rd, 5'd0, FUNCT_JALR);
            OP_ADDI:  e.word = i_word(OPC_ADDI, rs, rt, imm);
            OP_ADDIU: e.word = i_word(OPC_ADDIU, rs, rt, imm);
            OP_SLTI:  e.word = i_word(OPC_SLTI, rs, rt, imm);
            OP_SLTIU: e.word = i_word(OPC_SLTIU, rs, rt, imm);
            OP_ANDI:  e.word = i_word(OPC_ANDI, rs, rt, imm);
            OP_ORI:   e.word = i_word(OPC_ORI, rs, rt, imm);
            OP_XORI:  e.word = i_word(OPC_XORI, rs, rt, imm);
            OP_LUI:   e.word = i_word(OPC_LUI, 5'd0, rt, imm);
            OP_LW:    e.word = i_word(OPC_LW, rs, rt, imm);
            OP_SW:    e.word = i_word(OPC_SW, rs, rt, imm);
            OP_BEQ:   e.word = i_word(OPC_BEQ, rs, rt, imm);
            OP_BNE:   e.word = i_word(OPC_BNE, rs, rt, imm);
            OP_J:     e.word = j_word(OPC_J, tgt);
            OP_JAL:   e.word = j_word(OPC_JAL, tgt);
            default:  e.legal = 1'b0;
        endcase
        return e;
    endfunction

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] imem_addr_q, imem_addr_d;
    logic [ADDR_W-1:0] instr_count_q, instr_count_d;
    logic              err_q, err_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    enc_t enc;
    logic fifo_full, fifo_empty;
    logic req_fire, push, pop;

    assign enc = encode(req_op, req_rs, req_rt, req_rd, req_shamt, req_imm, req_target);

    // Qualified with rst so nothing is handshaken during the reset cycle itself.
    assign req_ready = (state_q == ST_LOAD) && !fifo_full && !rst;
    assign imem_we   = !fifo_empty && !rst;
    assign req_fire  = req_valid && req_ready;
    assign push      = req_fire && enc.legal;
    assign pop       = imem_we && imem_ready;

    instr_enc_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (32)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata (enc.word),
        .pop   (pop),
        .rdata (imem_wdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        state_d       = state_q;
        imem_addr_d   = imem_addr_q;
        instr_count_d = instr_count_q;
        err_d         = err_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d       = ST_LOAD;
                    imem_addr_d   = BASE_ADDR;
                    instr_count_d = '0;
                    err_d         = 1'b0;
                end
            end
            ST_LOAD:  if (req_fire && req_last) state_d = ST_DRAIN;
            ST_DRAIN: if (fifo_empty) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
        if (pop) begin
            imem_addr_d   = imem_addr_q + ADDR_STEP;
            instr_count_d = instr_count_q + COUNT_ONE;
        end
        if (req_fire && !enc.legal) err_d = 1'b1;
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            imem_addr_q   <= BASE_ADDR;
            instr_count_q <= '0;
            err_q         <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            imem_addr_q   <= imem_addr_d;
            instr_count_q <= instr_count_d;
            err_q         <= err_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
        end
    end

    assign imem_addr   = imem_addr_q;
    assign instr_count = instr_count_q;
    assign err_illegal = err_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Randomized bench for instr_encoder_loader: two instances (base 0 and a base just
// below the wrap point) share stimulus; a queue-based reference model checks writes.
module tb_instr_encoder_loader;
    import instr_enc_pkg::*;

    localparam logic [31:0] BASE_B = 32'hFFFF_FFFC;

    typedef struct {
        logic [4:0]  op, rs, rt, rd, sh;
        logic [15:0] imm;
        logic [25:0] tgt;
    } req_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1, start = 1'b0, req_valid = 1'b0, req_last = 1'b0;
    logic        imem_ready = 1'b0;
    logic [4:0]  req_op = '0, req_rs = '0, req_rt = '0, req_rd = '0, req_shamt = '0;
    logic [15:0] req_imm = '0;
    logic [25:0] req_target = '0;

    logic        req_ready_a, imem_we_a, busy_a, done_a, err_a;
    logic [31:0] imem_addr_a, imem_wdata_a, instr_count_a;
    logic        req_ready_b, imem_we_b, busy_b, done_b, err_b;
    logic [31:0] imem_addr_b, imem_wdata_b, instr_count_b;

    instr_encoder_loader dut_a (
        .clk(clk), .rst(rst), .start(start), .req_valid(req_valid), .req_ready(req_ready_a),
        .req_op(req_op), .req_rs(req_rs), .req_rt(req_rt), .req_rd(req_rd),
        .req_shamt(req_shamt), .req_imm(req_imm), .req_target(req_target), .req_last(req_last),
        .imem_we(imem_we_a), .imem_addr(imem_addr_a), .imem_wdata(imem_wdata_a),
        .imem_ready(imem_ready), .busy(busy_a), .done(done_a), .err_illegal(err_a),
        .instr_count(instr_count_a)
    );

    instr_encoder_loader #(.BASE_ADDR(BASE_B)) dut_b (
        .clk(clk), .rst(rst), .start(start), .req_valid(req_valid), .req_ready(req_ready_b),
        .req_op(req_op), .req_rs(req_rs), .req_rt(req_rt), .req_rd(req_rd),
        .req_shamt(req_shamt), .req_imm(req_imm), .req_target(req_target), .req_last(req_last),
        .imem_we(imem_we_b), .imem_addr(imem_addr_b), .imem_wdata(imem_wdata_b),
        .imem_ready(imem_ready), .busy(busy_b), .done(done_b), .err_illegal(err_b),
        .instr_count(instr_count_b)
    );

    always #5 clk = ~clk;

    int          errors = 0, checks = 0;
    logic [31:0] exp_q[$];
    int          wr_idx = 0, n_legal = 0;
    bit          exp_err = 0, stall = 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Reference encoding built from field positions with plain arithmetic.
    function automatic logic [31:0] ref_word(input req_t r);
        int unsigned rs = r.rs, rt = r.rt, rd = r.rd, sh = r.sh, imm = r.imm, tgt = r.tgt;
        int unsigned rf = rs * 2**21 + rt * 2**16 + rd * 2**11;
        case (r.op)
            OP_ADD:   return rf + 'h20;
            OP_ADDU:  return rf + 'h21;
            OP_SUB:   return rf + 'h22;
            OP_SUBU:  return rf + 'h23;
            OP_AND:   return rf + 'h24;
            OP_OR:    return rf + 'h25;
            OP_XOR:   return rf + 'h26;
            OP_NOR:   return rf + 'h27;
            OP_SLT:   return rf + 'h2A;
            OP_SLL:   return rt * 2**16 + rd * 2**11 + sh * 64 + 'h00;
            OP_SRL:   return rt * 2**16 + rd * 2**11 + sh * 64 + 'h02;
            OP_SRA:   return rt * 2**16 + rd * 2**11 + sh * 64 + 'h03;
            OP_SLLV:  return rf + 'h04;
            OP_SRLV:  return rf + 'h06;
            OP_SRAV:  return rf + 'h07;
            OP_JR:    return rs * 2**21 + 'h08;
            OP_JALR:  return rs * 2**21 + rd * 2**11 + 'h09;
            OP_ADDI:  return 'h08 * 2**26 + rs * 2**21 + rt * 2**16 + imm;
            OP_ADDIU: return 'h09 * 2**26 + rs * 2**21 + rt * 2**16 + imm;
            OP_SLTI:  return 'h0A * 2**26 + rs * 2**21 + rt * 2**16 + imm;
            OP_SLTIU: return 'h0B * 2**26 + rs * 2**21 + rt * 2**16 + imm;
            OP_ANDI:  return 'h0C * 2**26 + rs * 2**21 + rt * 2**16 + imm;
            OP_ORI:   return 'h0D * 2**26 + rs * 2**21 + rt * 2**16 + imm;
            OP_XORI:  return 'h0E * 2**26 + rs * 2**21 + rt * 2**16 + imm;
            OP_LUI:   return 'h0F * 2**26 + rt * 2**16 + imm;
            OP_LW:    return 'h23 * 2**26 + rs * 2**21 + rt * 2**16 + imm;
            OP_SW:    return 'h2B * 2**26 + rs * 2**21 + rt * 2**16 + imm;
            OP_BEQ:   return 'h04 * 2**26 + rs * 2**21 + rt * 2**16 + imm;
            OP_BNE:   return 'h05 * 2**26 + rs * 2**21 + rt * 2**16 + imm;
            OP_J:     return 'h02 * 2**26 + tgt;
            OP_JAL:   return 'h03 * 2**26 + tgt;
            default:  return 32'h0;
        endcase
    endfunction

    function automatic req_t rand_req(input bit allow_ill);
        req_t r;
        r.op  = 5'($urandom_range(0, 30));
        if (allow_ill && $urandom_range(0, 9) == 0) r.op = 5'd31;
        r.rs  = 5'($urandom);
        r.rt  = 5'($urandom);
        r.rd  = 5'($urandom);
        r.sh  = 5'($urandom);
        r.imm = 16'($urandom);
        r.tgt = 26'($urandom);
        return r;
    endfunction

    function automatic req_t mk(input logic [4:0] op, input logic [4:0] rs, input logic [4:0] rt,
                                input logic [4:0] rd, input logic [4:0] sh,
                                input logic [15:0] imm, input logic [25:0] tgt);
        req_t r;
        r.op = op; r.rs = rs; r.rt = rt; r.rd = rd; r.sh = sh; r.imm = imm; r.tgt = tgt;
        return r;
    endfunction

    // Memory side: random backpressure unless stalled.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            imem_ready = stall ? 1'b0 : ($urandom_range(0, 3) != 0);
        end
    end

    // Write monitor: each accepted memory write must match the model queue head.
    always @(negedge clk) begin
        if (!rst && imem_we_a && imem_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", 32'(exp_q.size()), 32'd1);
            end else begin
                check("wdata_a", imem_wdata_a, exp_q[0]);
                check("wdata_b", imem_wdata_b, exp_q[0]);
                check("addr_a", imem_addr_a, 32'(wr_idx * 4));
                check("addr_b", imem_addr_b, BASE_B + 32'(wr_idx * 4));
                $display("write #%0d addr_a=0x%08h addr_b=0x%08h data=0x%08h",
                         wr_idx, imem_addr_a, imem_addr_b, imem_wdata_a);
                void'(exp_q.pop_front());
                wr_idx++;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input req_t r, input bit last);
        req_op = r.op; req_rs = r.rs; req_rt = r.rt; req_rd = r.rd;
        req_shamt = r.sh; req_imm = r.imm; req_target = r.tgt;
        req_last = last;
        req_valid = 1'b1;
    endtask

    task automatic model_accept(input req_t r);
        if (r.op == 5'd31) begin
            exp_err = 1;
        end else begin
            exp_q.push_back(ref_word(r));
            n_legal++;
        end
    endtask

    task automatic send(input req_t r, input bit last);
        int n;
        drive(r, last);
        for (n = 0; n < 500; n++) begin
            @(negedge clk);
            if (req_ready_a) break;
        end
        if (n == 500) check("req_accept_timeout", 32'(req_ready_a), 32'd1);
        else model_accept(r);
        step();
        req_valid = 1'b0;
        req_last  = 1'b0;
    endtask

    task automatic start_load();
        start = 1'b1;
        step();
        start = 1'b0;
        exp_err = 0; wr_idx = 0; n_legal = 0;
        exp_q.delete();
        check("start_busy", 32'(busy_a), 32'd1);
        check("start_count", instr_count_a, 32'd0);
        check("start_addr_a", imem_addr_a, 32'd0);
        check("start_addr_b", imem_addr_b, BASE_B);
        check("start_err", 32'(err_a), 32'd0);
    endtask

    task automatic wait_done();
        bit found = 0;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            if (done_a) begin
                found = 1;
                break;
            end
        end
        check("done_seen", 32'(found), 32'd1);
        if (found) begin
            check("done_queue_empty", 32'(exp_q.size()), 32'd0);
            check("done_count_a", instr_count_a, 32'(n_legal));
            check("done_count_b", instr_count_b, 32'(n_legal));
            check("done_err", 32'(err_a), 32'(exp_err));
            check("done_busy", 32'(busy_a), 32'd1);
            check("done_b", 32'(done_b), 32'd1);
            @(negedge clk);
            check("done_one_cycle", 32'(done_a), 32'd0);
            check("idle_after_done", 32'(busy_a), 32'd0);
        end
        $display("program done: words=%0d illegal=%0d", n_legal, exp_err);
    endtask

    initial begin
        req_t reqs[6];
        int   k, nprog;

        // Reset state
        step(); step();
        rst = 1'b0;
        check("rst_busy", 32'(busy_a), 32'd0);
        check("rst_done", 32'(done_a), 32'd0);
        check("rst_we", 32'(imem_we_a), 32'd0);
        check("rst_ready", 32'(req_ready_a), 32'd0);
        check("rst_addr_a", imem_addr_a, 32'd0);
        check("rst_addr_b", imem_addr_b, BASE_B);
        check("rst_err", 32'(err_a), 32'd0);
        check("rst_count", instr_count_a, 32'd0);
        stall = 0;

        // Single add
        start_load();
        send(mk(OP_ADD, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0), 1);
        check("t1_word", ref_word(mk(OP_ADD, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0)), 32'h0022_1820);
        wait_done();

        // lw / sll / j, with a stray start mid-program that must be ignored
        start_load();
        send(mk(OP_LW, 5'd29, 5'd8, 5'd0, 5'd0, 16'd4, 26'h0), 0);
        start = 1'b1; step(); start = 1'b0;
        send(mk(OP_SLL, 5'd7, 5'd1, 5'd2, 5'd4, 16'h0, 26'h0), 0);
        send(mk(OP_J, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h10), 1);
        wait_done();

        // Memory stalled: FIFO fills to DEPTH, head held stable
        stall = 1; imem_ready = 1'b0;
        start_load();
        for (int i = 0; i < 6; i++) reqs[i] = rand_req(0);
        k = 0;
        drive(reqs[0], 0);
        for (int cyc = 0; cyc < 10; cyc++) begin
            @(negedge clk);
            if (imem_we_a && exp_q.size() > 0) begin
                check("stall_addr", imem_addr_a, 32'd0);
                check("stall_data", imem_wdata_a, exp_q[0]);
            end
            if (req_ready_a && k < 6) begin
                model_accept(reqs[k]);
                k++;
            end
            step();
            if (k < 6) drive(reqs[k], 0);
            else req_valid = 1'b0;
        end
        req_valid = 1'b0;
        check("stall_accepted", 32'(k), 32'd4);
        check("stall_req_ready", 32'(req_ready_a), 32'd0);
        check("stall_we", 32'(imem_we_a), 32'd1);
        stall = 0;
        for (int i = k; i < 6; i++) send(reqs[i], i == 5);
        wait_done();

        // Undefined op between two adds
        start_load();
        send(mk(OP_ADD, 5'd4, 5'd5, 5'd6, 5'd0, 16'h0, 26'h0), 0);
        send(mk(5'd31, 5'd1, 5'd1, 5'd1, 5'd1, 16'h1, 26'h1), 0);
        check("illegal_err", 32'(err_a), 32'd1);
        send(mk(OP_ADD, 5'd7, 5'd8, 5'd9, 5'd0, 16'h0, 26'h0), 1);
        wait_done();

        // Reset mid-load with three words queued
        stall = 1; imem_ready = 1'b0;
        start_load();
        for (int i = 0; i < 3; i++) send(rand_req(0), 0);
        rst = 1'b1;
        step();
        check("midrst_we", 32'(imem_we_a), 32'd0);
        check("midrst_busy", 32'(busy_a), 32'd0);
        check("midrst_addr_a", imem_addr_a, 32'd0);
        check("midrst_addr_b", imem_addr_b, BASE_B);
        rst = 1'b0;
        exp_q.delete();
        step();
        check("midrst_we_after", 32'(imem_we_a), 32'd0);
        stall = 0;

        // Random programs, occasionally ending on an undefined op
        for (int p = 0; p < 10; p++) begin
            start_load();
            nprog = $urandom_range(1, 9);
            for (int i = 0; i < nprog; i++) begin
                repeat ($urandom_range(0, 2)) step();
                send(rand_req(1), i == nprog - 1);
            end
            wait_done();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
